// File: rtl/game_ctrl.sv
// game_ctrl: game-flow controller for a VGA sprite game.
//
// Tracks the game state, the lives, the frame score and the speed level.
// A frame tick is taken on every falling edge of vs, so the score counts
// frames. Collisions between the player sprite and any hazard channel cost a
// life. Play only (re)starts during vertical blanking.
//
// Optional feature: define GAME_CTRL_PAUSE_EN to enable the RUN<->PAUSE
// toggle on pause rising edges. Without it the pause input is ignored.
//
// Ports:
//   CLK          system clock, rising edge
//   clrn         asynchronous active-low reset
//   start        start/restart request (level in IDLE, rising edge in OVER)
//   pause        pause toggle request (rising edge, GAME_CTRL_PAUSE_EN only)
//   vs           VGA vertical sync, 0 = blanking
//   px_player    player sprite pixel active
//   px_haz       hazard sprite pixels, one bit per channel
//   game_status  1 only in RUN
//   state        current state code
//   lives        lives remaining
//   score        frames survived in RUN (saturating)
//   speed        score >> LVL_SHIFT, saturated at 15
//   hit_id       hazard channels involved in the last hit
module game_ctrl #(
  parameter int unsigned N_HAZ      = 2,
  parameter int unsigned LIVES      = 3,
  parameter int unsigned SCORE_W    = 16,
  parameter int unsigned HIT_FRAMES = 60,
  parameter int unsigned LVL_SHIFT  = 8
) (
  input  logic               CLK,
  input  logic               clrn,
  input  logic               start,
  input  logic               pause,
  input  logic               vs,
  input  logic               px_player,
  input  logic [N_HAZ-1:0]   px_haz,
  output logic               game_status,
  output logic [2:0]         state,
  output logic [3:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         speed,
  output logic [N_HAZ-1:0]   hit_id
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArmed = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StHit   = 3'd4,
    StOver  = 3'd5
  } state_e;

  localparam logic [3:0]         LivesInit = 4'(LIVES);
  localparam logic [7:0]         HitLast   = 8'(HIT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] LvlMax    = SCORE_W'(15);

  state_e             state_q, state_d;
  logic [3:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [N_HAZ-1:0]   hit_id_q, hit_id_d;
  logic [7:0]         hit_cnt_q, hit_cnt_d;
  logic               vs_q;
  logic               start_q;

  logic               frame_tick;
  logic               start_rise;
  logic [N_HAZ-1:0]   hit_vec;
  logic               collide;
  logic [SCORE_W-1:0] lvl;

  assign frame_tick = vs_q & ~vs;
  assign start_rise = start & ~start_q;
  assign hit_vec    = px_haz & {N_HAZ{px_player}};
  assign collide    = |hit_vec;

`ifdef GAME_CTRL_PAUSE_EN
  logic pause_q;
  logic pause_rise;

  assign pause_rise = pause & ~pause_q;

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      pause_q <= 1'b0;
    end else begin
      pause_q <= pause;
    end
  end
`else
  logic unused_pause;
  assign unused_pause = pause;
`endif

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      state_q   <= StIdle;
      lives_q   <= 4'd0;
      score_q   <= '0;
      hit_id_q  <= '0;
      hit_cnt_q <= 8'd0;
      vs_q      <= 1'b1;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      hit_id_q  <= hit_id_d;
      hit_cnt_q <= hit_cnt_d;
      vs_q      <= vs;
      start_q   <= start;
    end
  end

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    score_d   = score_q;
    hit_id_d  = hit_id_q;
    hit_cnt_d = hit_cnt_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StArmed;
          lives_d  = LivesInit;
          score_d  = '0;
          hit_id_d = '0;
        end
      end

      // Wait for blanking so play never begins mid-frame.
      StArmed: begin
        if (!vs) begin
          state_d = StRun;
        end
      end

      StRun: begin
        // Collision wins over pause and over a same-cycle score increment.
        if (collide) begin
          hit_id_d  = hit_vec;
          lives_d   = lives_q - 4'd1;
          hit_cnt_d = 8'd0;
          state_d   = (lives_q > 4'd1) ? StHit : StOver;
        end else begin
          if (frame_tick && (score_q != '1)) begin
            score_d = score_q + 1'b1;
          end
`ifdef GAME_CTRL_PAUSE_EN
          if (pause_rise) begin
            state_d = StPause;
          end
`endif
        end
      end

`ifdef GAME_CTRL_PAUSE_EN
      // Resume through ARMED so play restarts in blanking.
      StPause: begin
        if (pause_rise) begin
          state_d = StArmed;
        end
      end
`endif

      StHit: begin
        if (frame_tick) begin
          if (hit_cnt_q == HitLast) begin
            hit_cnt_d = 8'd0;
            state_d   = StArmed;
          end else begin
            hit_cnt_d = hit_cnt_q + 8'd1;
          end
        end
      end

      // Edge-detected so a button held through the fatal hit does not re-arm.
      StOver: begin
        if (start_rise) begin
          state_d  = StArmed;
          lives_d  = LivesInit;
          score_d  = '0;
          hit_id_d = '0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    lvl   = score_q >> LVL_SHIFT;
    speed = (lvl >= LvlMax) ? 4'd15 : 4'(lvl);
  end

  assign game_status = (state_q == StRun);
  assign state       = state_q;
  assign lives       = lives_q;
  assign score       = score_q;
  assign hit_id      = hit_id_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Testbench for game_ctrl. Two instances share all inputs: u_dut uses the
// default parameters, u_dut2 has a single life, an 8-bit score and
// LVL_SHIFT=3 so saturation and the fatal hit occur in the same run.
module tb_game_ctrl;

  logic       CLK;
  logic       clrn;
  logic       start;
  logic       pause;
  logic       vs;
  logic       px_player;
  logic [1:0] px_haz;

  logic        gs1;
  logic [2:0]  st1;
  logic [3:0]  lv1;
  logic [15:0] sc1;
  logic [3:0]  sp1;
  logic [1:0]  hit1;

  logic        gs2;
  logic [2:0]  st2;
  logic [3:0]  lv2;
  logic [7:0]  sc2;
  logic [3:0]  sp2;
  logic [1:0]  hit2;

  int n_pass  = 0;
  int n_total = 0;

  game_ctrl u_dut (
    .CLK         (CLK),
    .clrn        (clrn),
    .start       (start),
    .pause       (pause),
    .vs          (vs),
    .px_player   (px_player),
    .px_haz      (px_haz),
    .game_status (gs1),
    .state       (st1),
    .lives       (lv1),
    .score       (sc1),
    .speed       (sp1),
    .hit_id      (hit1)
  );

  game_ctrl #(
    .N_HAZ      (2),
    .LIVES      (1),
    .SCORE_W    (8),
    .HIT_FRAMES (3),
    .LVL_SHIFT  (3)
  ) u_dut2 (
    .CLK         (CLK),
    .clrn        (clrn),
    .start       (start),
    .pause       (pause),
    .vs          (vs),
    .px_player   (px_player),
    .px_haz      (px_haz),
    .game_status (gs2),
    .state       (st2),
    .lives       (lv2),
    .score       (sc2),
    .speed       (sp2),
    .hit_id      (hit2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        start;
    logic        vs;
    logic        pp;
    logic [1:0]  haz;
    logic [2:0]  st;
    logic [3:0]  lv;
    logic [15:0] sc;
    logic        gs;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One video frame: two cycles of blanking then two of active video.
  task automatic frame();
    vs = 1'b0;
    step();
    step();
    vs = 1'b1;
    step();
    step();
  endtask

  initial begin
    clrn      = 1'b0;
    start     = 1'b0;
    pause     = 1'b0;
    vs        = 1'b1;
    px_player = 1'b0;
    px_haz    = 2'b00;

    //          start vs  pp  haz    state lives score gs
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 2'b00, 3'd0, 4'd0, 16'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'b00, 3'd1, 4'd3, 16'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'b00, 3'd1, 4'd3, 16'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'b00, 3'd1, 4'd3, 16'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'b00, 3'd2, 4'd3, 16'd0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'b00, 3'd2, 4'd3, 16'd0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'b00, 3'd2, 4'd3, 16'd0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'b00, 3'd2, 4'd3, 16'd1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'b00, 3'd2, 4'd3, 16'd1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'b00, 3'd2, 4'd3, 16'd2, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 2'b00, 3'd2, 4'd3, 16'd2, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 2'b11, 3'd2, 4'd3, 16'd2, 1'b1};

    // Reset values while clrn is held low.
    #12;
    chk("rst_state", 32'(st1), 32'd0);
    chk("rst_lives", 32'(lv1), 32'd0);
    chk("rst_score", 32'(sc1), 32'd0);
    chk("rst_hit_id", 32'(hit1), 32'd0);
    chk("rst_status", 32'(gs1), 32'd0);
    chk("rst_speed", 32'(sp1), 32'd0);

    @(negedge CLK);
    clrn = 1'b1;

    // Start, arm, enter RUN in blanking, first frames, near-miss pixels.
    for (int i = 0; i < 12; i++) begin
      start     = vecs[i].start;
      vs        = vecs[i].vs;
      px_player = vecs[i].pp;
      px_haz    = vecs[i].haz;
      step();
      chk($sformatf("vec%0d_state", i), 32'(st1), 32'(vecs[i].st));
      chk($sformatf("vec%0d_lives", i), 32'(lv1), 32'(vecs[i].lv));
      chk($sformatf("vec%0d_score", i), 32'(sc1), 32'(vecs[i].sc));
      chk($sformatf("vec%0d_status", i), 32'(gs1), 32'(vecs[i].gs));
    end
    px_player = 1'b0;
    px_haz    = 2'b00;
    chk("dut2_lives_init", 32'(lv2), 32'd1);
    chk("dut2_score_early", 32'(sc2), 32'd2);

    // 300 frames total; dut2 saturates score and speed.
    repeat (298) frame();
    chk("score_300", 32'(sc1), 32'd300);
    chk("speed_1", 32'(sp1), 32'd1);
    chk("dut2_score_sat", 32'(sc2), 32'd255);
    chk("dut2_speed_sat", 32'(sp2), 32'd15);
    frame();
    chk("dut2_score_hold", 32'(sc2), 32'd255);
    chk("score_301", 32'(sc1), 32'd301);

`ifdef GAME_CTRL_PAUSE_EN
    pause = 1'b1;
    step();
    chk("pause_enter", 32'(st1), 32'd3);
    chk("dut2_pause_enter", 32'(st2), 32'd3);
    pause = 1'b0;
    step();
    px_player = 1'b1;
    px_haz    = 2'b11;
    repeat (10) frame();
    chk("pause_score", 32'(sc1), 32'd301);
    chk("pause_lives", 32'(lv1), 32'd3);
    chk("pause_hit_id", 32'(hit1), 32'd0);
    chk("dut2_pause_lives", 32'(lv2), 32'd1);
    chk("pause_held", 32'(st1), 32'd3);
    px_player = 1'b0;
    px_haz    = 2'b00;
    pause     = 1'b1;
    step();
    chk("pause_exit_armed", 32'(st1), 32'd1);
    pause = 1'b0;
    step();
    frame();
    chk("resume_run", 32'(st1), 32'd2);
    chk("resume_score", 32'(sc1), 32'd301);
`else
    pause = 1'b1;
    step();
    pause = 1'b0;
    step();
    chk("pause_ignored", 32'(st1), 32'd2);
    chk("dut2_pause_ignored", 32'(st2), 32'd2);
`endif

    // start held across the fatal hit on dut2.
    start = 1'b1;
    step();
    chk("start_in_run", 32'(st1), 32'd2);
    px_player = 1'b1;
    px_haz    = 2'b10;
    step();
    chk("hit_state", 32'(st1), 32'd4);
    chk("hit_lives", 32'(lv1), 32'd2);
    chk("hit_id", 32'(hit1), 32'd2);
    chk("hit_status", 32'(gs1), 32'd0);
    chk("over_state", 32'(st2), 32'd5);
    chk("over_lives", 32'(lv2), 32'd0);
    chk("over_hit_id", 32'(hit2), 32'd2);

    // Collisions keep arriving during HIT and OVER and must be ignored.
    px_haz = 2'b01;
    repeat (59) frame();
    chk("hit_59_state", 32'(st1), 32'd4);
    chk("hit_ign_lives", 32'(lv1), 32'd2);
    chk("hit_ign_id", 32'(hit1), 32'd2);
    chk("over_held_start", 32'(st2), 32'd5);
    chk("over_ign_lives", 32'(lv2), 32'd0);
    chk("over_ign_id", 32'(hit2), 32'd2);
    chk("over_score_hold", 32'(sc2), 32'd255);
    px_player = 1'b0;
    px_haz    = 2'b00;
    vs        = 1'b0;
    step();
    chk("hit_60_armed", 32'(st1), 32'd1);
    step();
    chk("rearm_run", 32'(st1), 32'd2);
    chk("rearm_lives", 32'(lv1), 32'd2);
    vs = 1'b1;
    step();
    step();

    start = 1'b0;
    step();
    chk("over_start_low", 32'(st2), 32'd5);
    start = 1'b1;
    step();
    chk("over_restart", 32'(st2), 32'd1);
    chk("over_restart_score", 32'(sc2), 32'd0);
    chk("over_restart_lives", 32'(lv2), 32'd1);
    chk("over_restart_hit", 32'(hit2), 32'd0);
    start = 1'b0;

    // Asynchronous reset in the middle of a HIT.
    px_player = 1'b1;
    px_haz    = 2'b01;
    step();
    chk("hit2_state", 32'(st1), 32'd4);
    chk("hit2_lives", 32'(lv1), 32'd1);
    chk("hit2_id", 32'(hit1), 32'd1);
    chk("armed_ign_lives", 32'(lv2), 32'd1);
    px_player = 1'b0;
    px_haz    = 2'b00;
    step();
    #3;
    clrn = 1'b0;
    #1;
    chk("arst_state", 32'(st1), 32'd0);
    chk("arst_lives", 32'(lv1), 32'd0);
    chk("arst_score", 32'(sc1), 32'd0);
    chk("arst_hit_id", 32'(hit1), 32'd0);
    chk("arst_dut2_state", 32'(st2), 32'd0);
    step();
    clrn = 1'b1;
    step();
    chk("post_rst_idle", 32'(st1), 32'd0);
    start = 1'b1;
    step();
    chk("post_rst_armed", 32'(st1), 32'd1);
    chk("post_rst_lives", 32'(lv1), 32'd3);
    start = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
